// File: rtl/bp_me_pkg.sv
// Shared CCE/LCE types: processor config table, BedRock command and coherence enums,
// command-sender FSM states, and the LCE command header declaration macro.
package bp_me_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

  typedef struct packed {
    int unsigned num_lce;
    int unsigned lce_id_width;
    int unsigned lce_assoc_width;
    int unsigned paddr_width;
    int unsigned cce_id_width;
  } bp_proc_param_s;

  localparam bp_proc_param_s bp_default_cfg_lp = '{
    num_lce: 32'd4, lce_id_width: 32'd2, lce_assoc_width: 32'd3,
    paddr_width: 32'd40, cce_id_width: 32'd2};

  function automatic bp_proc_param_s bp_proc_param(input bp_params_e cfg);
    bp_proc_param_s p;
    case (cfg)
      e_bp_default_cfg: p = bp_default_cfg_lp;
      default:          p = bp_default_cfg_lp;
    endcase
    return p;
  endfunction

  localparam int bp_cmd_type_width_lp  = 4;
  localparam int bp_coh_state_width_lp = 3;

  typedef enum logic [bp_cmd_type_width_lp-1:0] {
    e_bedrock_cmd_sync      = 4'd0,
    e_bedrock_cmd_set_clear = 4'd1,
    e_bedrock_cmd_inv       = 4'd2,
    e_bedrock_cmd_set_state = 4'd3,
    e_bedrock_cmd_data      = 4'd4
  } bp_bedrock_cmd_type_e;

  typedef enum logic [bp_coh_state_width_lp-1:0] {
    e_COH_I = 3'd0,
    e_COH_S = 3'd1,
    e_COH_E = 3'd2,
    e_COH_F = 3'd3,
    e_COH_M = 3'd6,
    e_COH_O = 3'd7
  } bp_coh_states_e;

  typedef enum logic [1:0] {
    e_cmd_sender_idle     = 2'd0,
    e_cmd_sender_send     = 2'd1,
    e_cmd_sender_wait_ack = 2'd2,
    e_cmd_sender_done     = 2'd3
  } bp_cce_cmd_sender_state_e;

  function automatic int bp_lce_cmd_header_width(input bp_proc_param_s p);
    return bp_coh_state_width_lp + int'(p.lce_assoc_width) + int'(p.cce_id_width)
         + int'(p.lce_id_width) + int'(p.paddr_width) + bp_cmd_type_width_lp;
  endfunction

endpackage

`ifndef BP_ME_DECLARE_LCE_IF
`define BP_ME_DECLARE_LCE_IF
`define DECLARE_BP_BEDROCK_LCE_IF(paddr_width_mp, lce_id_width_mp, cce_id_width_mp, lce_assoc_width_mp) \
  typedef struct packed { \
    bp_coh_states_e                 state; \
    logic [lce_assoc_width_mp-1:0]  way_id; \
    logic [cce_id_width_mp-1:0]     src_id; \
    logic [lce_id_width_mp-1:0]     dst_id; \
    logic [paddr_width_mp-1:0]      addr; \
    bp_bedrock_cmd_type_e           msg_type; \
  } bp_bedrock_lce_cmd_header_s
`endif

// File: rtl/bsg_priority_encode.sv
// Priority encoder: index of the lowest (lo_to_hi_p=1) or highest set bit; combinational.
// No handshake; v_o flags a non-empty input, addr_o is 0 when empty.
module bsg_priority_encode
  #(parameter int width_p = 4
    , parameter int lo_to_hi_p = 1
    , localparam int addr_width_lp = (width_p > 1) ? $clog2(width_p) : 1
    )
  (input  logic [width_p-1:0]       data_i
   , output logic [addr_width_lp-1:0] addr_o
   , output logic                     v_o
   );

  always_comb begin
    addr_o = '0;
    if (lo_to_hi_p != 0) begin
      for (int k = width_p-1; k >= 0; k--)
        if (data_i[k]) addr_o = addr_width_lp'(k);
    end else begin
      for (int k = 0; k < width_p; k++)
        if (data_i[k]) addr_o = addr_width_lp'(k);
    end
  end

  assign v_o = |data_i;

endmodule

// File: rtl/bp_cce_lce_cmd_sender.sv
// Broadcasts one BedRock inv/set-state LCE command per sharer; BP_CCE_CMD_SENDER_ACK_EN adds inv-ack collection.
// Latency: start accepted in cycle 0, first command valid in cycle 1, peak one command per cycle.
// Backpressure: command valid and header hold steady until ready-and; excess acks are refused.
module bp_cce_lce_cmd_sender
  import bp_me_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_default_cfg
    , localparam bp_proc_param_s proc_lp = bp_proc_param(bp_params_p)
    , localparam int num_lce_p           = int'(proc_lp.num_lce)
    , localparam int lce_id_width_p      = int'(proc_lp.lce_id_width)
    , localparam int lce_assoc_width_p   = int'(proc_lp.lce_assoc_width)
    , localparam int paddr_width_p       = int'(proc_lp.paddr_width)
    , localparam int cce_id_width_p      = int'(proc_lp.cce_id_width)
    , localparam int cnt_width_lp        = $clog2(num_lce_p+1)
    , localparam int lce_cmd_msg_header_width_lp = bp_lce_cmd_header_width(proc_lp)
    )
  (input  logic                                   clk_i
   , input  logic                                 reset_n_i
   , input  logic                                 start_v_i
   , output logic                                 start_ready_o
   , input  logic [bp_cmd_type_width_lp-1:0]      cmd_type_i
   , input  logic [num_lce_p-1:0]                 sharers_i
   , input  logic                                 exclude_v_i
   , input  logic [lce_id_width_p-1:0]            exclude_lce_i
   , input  logic [paddr_width_p-1:0]             paddr_i
   , input  logic [lce_assoc_width_p-1:0]         way_id_i
   , input  logic [bp_coh_state_width_lp-1:0]     state_i
   , input  logic [cce_id_width_p-1:0]            cce_id_i
   , output logic [lce_cmd_msg_header_width_lp-1:0] lce_cmd_header_o
   , output logic                                 lce_cmd_v_o
   , input  logic                                 lce_cmd_ready_and_i
   , input  logic                                 ack_v_i
   , output logic                                 ack_ready_o
   , output logic                                 busy_o
   , output logic                                 done_o
   , output logic [cnt_width_lp-1:0]              sent_count_o
   );

  `DECLARE_BP_BEDROCK_LCE_IF(paddr_width_p, lce_id_width_p, cce_id_width_p, lce_assoc_width_p);

  localparam logic [1:0] idle_s     = e_cmd_sender_idle;
  localparam logic [1:0] send_s     = e_cmd_sender_send;
  localparam logic [1:0] wait_ack_s = e_cmd_sender_wait_ack;
  localparam logic [1:0] done_s     = e_cmd_sender_done;
  localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(num_lce_p);

  logic [1:0]                   state_q, state_d;
  logic [num_lce_p-1:0]         mask_q, mask_d;
  bp_bedrock_cmd_type_e         cmd_q, cmd_d;
  logic [paddr_width_p-1:0]     addr_q, addr_d;
  logic [lce_assoc_width_p-1:0] way_q, way_d;
  bp_coh_states_e               coh_q, coh_d;
  logic [cce_id_width_p-1:0]    src_q, src_d;
  logic [cnt_width_lp-1:0]      sent_q, sent_d;

  logic [lce_id_width_p-1:0]    dst_id;
  logic                         mask_v;
  logic [num_lce_p-1:0]         dst_onehot, exclude_mask;
  logic                         start_take, cmd_fire, cmd_ok;
  logic                         ack_wait, acks_done;
  bp_bedrock_lce_cmd_header_s   hdr;

  bsg_priority_encode
   #(.width_p(num_lce_p), .lo_to_hi_p(1))
   dst_enc
    (.data_i(mask_q)
     ,.addr_o(dst_id)
     ,.v_o(mask_v)
     );

  assign start_ready_o = (state_q == idle_s);
  assign busy_o        = ~start_ready_o;
  assign done_o        = (state_q == done_s);
  assign lce_cmd_v_o   = (state_q == send_s) & mask_v;
  assign sent_count_o  = sent_q;

  // Unsupported command types are consumed by the start handshake but start nothing.
  assign cmd_ok     = (cmd_type_i == e_bedrock_cmd_inv) || (cmd_type_i == e_bedrock_cmd_set_state);
  assign start_take = start_v_i & start_ready_o & cmd_ok;
  assign cmd_fire   = lce_cmd_v_o & lce_cmd_ready_and_i;

  assign dst_onehot   = num_lce_p'(1) << dst_id;
  assign exclude_mask = exclude_v_i ? (num_lce_p'(1) << exclude_lce_i) : '0;

`ifdef BP_CCE_CMD_SENDER_ACK_EN
  logic [cnt_width_lp-1:0] ack_q, ack_d;

  assign ack_ready_o = ((state_q == send_s) | (state_q == wait_ack_s))
                     & (cmd_q == e_bedrock_cmd_inv) & (ack_q != cnt_max_lp);
  assign ack_wait    = (cmd_q == e_bedrock_cmd_inv);
  // Compare next-state counts so an ack landing in the final cycle completes without a bubble.
  assign acks_done   = (ack_d == sent_d);

  always_comb begin
    ack_d = ack_q;
    if (start_take)
      ack_d = '0;
    else if (ack_v_i & ack_ready_o)
      ack_d = ack_q + cnt_width_lp'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ack_q <= '0;
    else            ack_q <= ack_d;
  end
`else
  logic unused_ack;
  assign unused_ack  = ack_v_i;
  assign ack_ready_o = 1'b0;
  assign ack_wait    = 1'b0;
  assign acks_done   = 1'b1;
`endif

  always_comb begin
    mask_d = mask_q;
    sent_d = sent_q;
    cmd_d  = cmd_q;
    addr_d = addr_q;
    way_d  = way_q;
    coh_d  = coh_q;
    src_d  = src_q;
    if (start_take) begin
      mask_d = sharers_i & ~exclude_mask;
      sent_d = '0;
      cmd_d  = bp_bedrock_cmd_type_e'(cmd_type_i);
      addr_d = paddr_i;
      way_d  = way_id_i;
      coh_d  = bp_coh_states_e'(state_i);
      src_d  = cce_id_i;
    end else if (cmd_fire) begin
      mask_d = mask_q & ~dst_onehot;
      if (sent_q != cnt_max_lp) sent_d = sent_q + cnt_width_lp'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      idle_s:     if (start_take) state_d = send_s;
      send_s:     if (mask_d == '0) state_d = (ack_wait && !acks_done) ? wait_ack_s : done_s;
      wait_ack_s: if (acks_done) state_d = done_s;
      default:    state_d = idle_s;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= idle_s;
      mask_q  <= '0;
      sent_q  <= '0;
      cmd_q   <= bp_bedrock_cmd_type_e'('0);
      addr_q  <= '0;
      way_q   <= '0;
      coh_q   <= bp_coh_states_e'('0);
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      sent_q  <= sent_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      way_q   <= way_d;
      coh_q   <= coh_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    hdr          = '0;
    hdr.state    = coh_q;
    hdr.way_id   = way_q;
    hdr.src_id   = src_q;
    hdr.dst_id   = dst_id;
    hdr.addr     = addr_q;
    hdr.msg_type = cmd_q;
  end

  assign lce_cmd_header_o = hdr;

endmodule
